median_window_sequencer: RTL and testbench
==========================================

// Module: median_window_sequencer
// PURPOSE
//  Splits the raw pixel stream into BUFF_SIZE-pixel windows and feeds them to the median chain
//  (first fill/check actor followed by iteration actors).
//  Bounds the number of windows in flight, collects one median per window in order, and
//  forwards each median to the output FIFO.
//  Sits between the source pixel FIFO and the first median actor's in_px FIFO port.
// PARAMETERS
//  BUFF_SIZE      11'd1024               pixels per window (median window length)
//  BUFF_SIZE_BIT  $clog2(BUFF_SIZE)+1    width of window pixel counter
//  MAX_INFLIGHT   4                      max windows issued but median not yet returned (>=1)
//  INFL_BIT       $clog2(MAX_INFLIGHT+1) width of in-flight counter
// PORTS
//  clock             in   1              system clock, rising edge
//  reset             in   1              asynchronous, active-high reset
//  enable            in   1              level; 1 = start/continue issuing windows
//  in_px             in   8              source pixel (FWFT FIFO data)
//  in_px_empty       in   1              source FIFO empty
//  in_px_rd          out  1              source FIFO read strobe
//  dp_px             out  8              pixel to median chain input FIFO
//  dp_px_wr          out  1              median chain input FIFO write strobe
//  dp_px_full        in   1              median chain input FIFO full
//  dp_median         in   8              median result from chain (FWFT FIFO data)
//  dp_median_empty   in   1              result FIFO empty
//  dp_median_rd      out  1              result FIFO read strobe
//  out_median        out  8              median to consumer
//  out_median_wr     out  1              consumer FIFO write strobe
//  out_median_full   in   1              consumer FIFO full
//  busy              out  1              1 while not IDLE or inflight != 0
//  windows_done      out  16             count of medians forwarded, wraps at 2^16
//  err_unexpected    out  1              sticky; a result appeared while inflight == 0
// BEHAVIOUR
//  Reset (async): state = IDLE; px_cnt = 0; inflight = 0; windows_done = 0; err_unexpected = 0.
//    All strobes are 0 while reset is high.
//  FSM:
//    IDLE   -> STREAM if enable && inflight < MAX_INFLIGHT.
//    STREAM -> on the last pixel (px_cnt == BUFF_SIZE-1 accepted), px_cnt <= 0 and inflight += 1. Then:
//              IDLE  if !enable;
//              STALL if new inflight == MAX_INFLIGHT;
//              else stay in STREAM.
//    STALL  -> STREAM if inflight < MAX_INFLIGHT && enable; IDLE if !enable.
//  Deasserting enable mid-window never truncates the window: STREAM completes all BUFF_SIZE pixels first.
//  Pixel path, combinational (0-cycle latency):
//    xfer = (state == STREAM) && !in_px_empty && !dp_px_full
//    in_px_rd = dp_px_wr = xfer; dp_px = in_px; px_cnt += 1 per xfer.
//  Result path, combinational:
//    rxfer = !dp_median_empty && !out_median_full && inflight != 0
//    dp_median_rd = out_median_wr = rxfer; out_median = dp_median
//    On rxfer: inflight -= 1 and windows_done += 1.
//  Simultaneous window close and rxfer in one cycle: inflight unchanged.
//    If in STREAM, continue without entering STALL.
//  Results are forwarded strictly in arrival order; the chain itself preserves window order.
//  dp_median_empty == 0 while inflight == 0:
//    do not read; err_unexpected <= 1 (sticky until reset).
//  inflight never exceeds MAX_INFLIGHT and never underflows.
//  Results keep draining in IDLE and STALL, so busy falls only after the last median is forwarded.
//  Reset asserted mid-window: counters clear immediately.
//    The partial window already in the chain is the integrator's to flush (chain reset shares the same reset).
// STRUCTURE
//  Shared package median_pkg: state encoding (IDLE/STREAM/STALL), BUFF_SIZE, MEDIAN_POS,
//    DEFAULT_PIVOT constants, pixel width 8.
//  Sub-module median_inflight_counter: up/down saturating counter with inc/dec/full/zero flags.
//  The rest is one FSM and the window counter in this file.
// TESTING
//  1 BUFF_SIZE=16, MAX_INFLIGHT=2, enable=1, 32 px, no results returned.
//    -> exactly 32 dp_px_wr; state STALL; inflight=2; in_px_rd=0 afterwards.
//  2 From test 1, push median 8'd42 then 8'd77 into the result FIFO.
//    -> out_median 42 then 77, windows_done=2, STREAM resumes on the cycle after the first rxfer.
//  3 dp_px_full toggled every other cycle during a window.
//    -> no pixel lost or duplicated; dp_px sequence equals the source sequence; window closes after 16 transfers.
//  4 enable dropped after pixel 5 of a window.
//    -> remaining 11 pixels still sent; IDLE after pixel 16; busy=1 until that median is forwarded.
//  5 Window close and rxfer in the same cycle with inflight=1.
//    -> inflight stays 1; no STALL entry.
//  6 Result FIFO non-empty with inflight=0.
//    -> dp_median_rd=0; err_unexpected=1 and held.
//    Async reset mid-window -> all outputs 0 within the same cycle; px_cnt=0.

Source files
------------

// File: rtl/median_pkg.sv
// Shared definitions for the median window sequencer: FSM encoding, pixel width
// and the default window geometry of the median chain.
package median_pkg;

    localparam int PX_W = 8;
    localparam logic [10:0] BUFF_SIZE = 11'd1024;
    localparam int MAX_INFLIGHT = 4;
    localparam int MEDIAN_POS = 512;
    localparam logic [PX_W-1:0] DEFAULT_PIVOT = 8'd128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        STALL  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/median_inflight_counter.sv
// Up/down counter of windows issued to the median chain whose result has not yet
// come back; saturates at both ends and holds when inc and dec coincide.
module median_inflight_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             zero
);

    assign full = (count == CNT_W'(MAX_COUNT));
    assign zero = (count == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && dec) begin
            count <= count;
        end else if (inc && !full) begin
            count <= count + 1'b1;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/median_window_sequencer.sv
// Cuts the source pixel stream into fixed windows for the median chain, bounds the
// number of windows in flight and forwards the returned medians in order.
module median_window_sequencer #(
    parameter int BUFF_SIZE     = int'(median_pkg::BUFF_SIZE),
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter int MAX_INFLIGHT  = median_pkg::MAX_INFLIGHT,
    parameter int INFL_BIT      = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [median_pkg::PX_W-1:0] in_px,
    input  logic                        in_px_empty,
    output logic                        in_px_rd,
    output logic [median_pkg::PX_W-1:0] dp_px,
    output logic                        dp_px_wr,
    input  logic                        dp_px_full,
    input  logic [median_pkg::PX_W-1:0] dp_median,
    input  logic                        dp_median_empty,
    output logic                        dp_median_rd,
    output logic [median_pkg::PX_W-1:0] out_median,
    output logic                        out_median_wr,
    input  logic                        out_median_full,
    output logic                        busy,
    output logic [15:0]                 windows_done,
    output logic                        err_unexpected
);

    import median_pkg::*;

    seq_state_t               state;
    seq_state_t               next_state;
    logic [BUFF_SIZE_BIT-1:0] px_cnt;
    logic [INFL_BIT-1:0]      inflight;
    logic                     infl_full;
    logic                     infl_zero;
    logic                     xfer;
    logic                     rxfer;
    logic                     win_last;
    logic                     can_issue;
    logic                     close_to_full;

    assign xfer     = (state == STREAM) && !in_px_empty && !dp_px_full;
    assign win_last = xfer && (px_cnt == BUFF_SIZE_BIT'(BUFF_SIZE - 1));
    assign rxfer    = !dp_median_empty && !out_median_full && !infl_zero;

    // A median leaving this cycle already frees a slot for the next window.
    assign can_issue     = !infl_full || rxfer;
    assign close_to_full = (inflight == INFL_BIT'(MAX_INFLIGHT - 1)) && !rxfer;

    assign dp_px      = in_px;
    assign out_median = dp_median;

    median_inflight_counter #(
        .MAX_COUNT (MAX_INFLIGHT),
        .CNT_W     (INFL_BIT)
    ) u_inflight (
        .clock (clock),
        .reset (reset),
        .inc   (win_last),
        .dec   (rxfer),
        .count (inflight),
        .full  (infl_full),
        .zero  (infl_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            px_cnt <= '0;
        end else if (win_last) begin
            px_cnt <= '0;
        end else if (xfer) begin
            px_cnt <= px_cnt + 1'b1;
        end
    end

    // A result with nothing outstanding is never read; it only latches the error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            windows_done   <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (rxfer) begin
                windows_done <= windows_done + 16'd1;
            end
            if (!dp_median_empty && infl_zero) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable && can_issue) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (win_last) begin
                    if (!enable) begin
                        next_state = IDLE;
                    end else if (close_to_full) begin
                        next_state = STALL;
                    end
                end
            end
            STALL: begin
                if (!enable) begin
                    next_state = IDLE;
                end else if (can_issue) begin
                    next_state = STREAM;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_px_rd      = xfer;
        dp_px_wr      = xfer;
        dp_median_rd  = rxfer;
        out_median_wr = rxfer;
        busy          = (state != IDLE) || !infl_zero;
    end

endmodule

// File: tb/tb_median_window_sequencer.sv
// Scoreboard bench for median_window_sequencer: source, chain and consumer FIFOs are
// modelled with queues; expected pixels and medians come from the stimulus itself.
module tb_median_window_sequencer;

    localparam int TB_BUFF = 16;
    localparam int TB_MAX  = 2;

    typedef logic [7:0] px_q_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  in_px = 8'h00;
    logic        in_px_empty = 1'b1;
    logic        in_px_rd;
    logic [7:0]  dp_px;
    logic        dp_px_wr;
    logic        dp_px_full = 1'b0;
    logic [7:0]  dp_median = 8'h00;
    logic        dp_median_empty = 1'b1;
    logic        dp_median_rd;
    logic [7:0]  out_median;
    logic        out_median_wr;
    logic        out_median_full = 1'b0;
    logic        busy;
    logic [15:0] windows_done;
    logic        err_unexpected;

    px_q_t src_q, res_q, exp_px, exp_med, chain_win, stim_win;
    bit    chain_auto, track_med, src_gap, res_gap, cons_gap;
    int    full_mode;
    int    px_wr_total, med_wr_total, cyc;
    bit    px_hist[int];
    int    med_cyc_q[$];
    int    mon_px, mon_fwd;
    logic [15:0] exp_done;
    int    n_checks, n_fail;

    median_window_sequencer #(
        .BUFF_SIZE    (TB_BUFF),
        .MAX_INFLIGHT (TB_MAX)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .in_px           (in_px),
        .in_px_empty     (in_px_empty),
        .in_px_rd        (in_px_rd),
        .dp_px           (dp_px),
        .dp_px_wr        (dp_px_wr),
        .dp_px_full      (dp_px_full),
        .dp_median       (dp_median),
        .dp_median_empty (dp_median_empty),
        .dp_median_rd    (dp_median_rd),
        .out_median      (out_median),
        .out_median_wr   (out_median_wr),
        .out_median_full (out_median_full),
        .busy            (busy),
        .windows_done    (windows_done),
        .err_unexpected  (err_unexpected)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] median_of(input px_q_t w);
        px_q_t s;
        s = w;
        s.sort();
        return s[TB_BUFF/2];
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: DUT strobe with no expected entry queued", name);
    endtask

    // Pushes random pixels into the source FIFO and the expected streams.
    task automatic apply_stimulus(input int n, input bit with_median);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = 8'($urandom_range(0, 255));
            src_q.push_back(p);
            exp_px.push_back(p);
            if (with_median) begin
                stim_win.push_back(p);
                if (stim_win.size() == TB_BUFF) begin
                    exp_med.push_back(median_of(stim_win));
                    stim_win.delete();
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        chain_auto = 0; track_med = 0; src_gap = 0; res_gap = 0; cons_gap = 0; full_mode = 0;
        src_q.delete(); res_q.delete(); exp_px.delete(); exp_med.delete();
        chain_win.delete(); stim_win.delete(); px_hist.delete(); med_cyc_q.delete();
        px_wr_total = 0; med_wr_total = 0; mon_px = 0; mon_fwd = 0; exp_done = '0;
        #1;
        check_output("rst_strobes", {in_px_rd, dp_px_wr, dp_median_rd, out_median_wr}, 4'b0000);
        check_output("rst_busy", busy, 0);
        check_output("rst_windows_done", windows_done, 0);
        check_output("rst_err", err_unexpected, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_px(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (px_wr_total < target && i < budget) begin
            @(negedge clock);
            i++;
        end
        check_output(name, px_wr_total, target);
    endtask

    task automatic wait_med(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (med_wr_total < target && i < budget) begin
            @(negedge clock);
            i++;
        end
        check_output(name, med_wr_total, target);
    endtask

    // Environment: drives FIFO-side inputs after each falling edge, then records
    // what the DUT transferred just before the next rising edge.
    always begin
        @(negedge clock);
        #1;
        in_px_empty = (src_q.size() == 0) || (src_gap && $urandom_range(0, 3) == 0);
        in_px = (src_q.size() != 0) ? src_q[0] : 8'h00;
        case (full_mode)
            1:       dp_px_full = ~dp_px_full;
            2:       dp_px_full = ($urandom_range(0, 2) == 0);
            default: dp_px_full = 1'b0;
        endcase
        dp_median_empty = (res_q.size() == 0) || (res_gap && $urandom_range(0, 2) == 0);
        dp_median = (res_q.size() != 0) ? res_q[0] : 8'h00;
        out_median_full = cons_gap && ($urandom_range(0, 3) == 0);
        #3;
        cyc++;
        if (in_px_rd && src_q.size() != 0) void'(src_q.pop_front());
        if (dp_px_wr) begin
            px_wr_total++;
            px_hist[cyc] = 1'b1;
            if (chain_auto) begin
                chain_win.push_back(dp_px);
                if (chain_win.size() == TB_BUFF) begin
                    res_q.push_back(median_of(chain_win));
                    chain_win.delete();
                end
            end
        end
        if (dp_median_rd && res_q.size() != 0) void'(res_q.pop_front());
        if (out_median_wr) begin
            med_wr_total++;
            med_cyc_q.push_back(cyc);
        end
    end

    // Monitor: compares every DUT transfer against the scoreboard queues.
    always begin
        @(negedge clock);
        #4;
        if (in_px_rd || dp_px_wr) begin
            check_output("px_handshake", {in_px_rd, dp_px_wr, in_px_empty, dp_px_full}, 4'b1100);
            if (exp_px.size() == 0) fail_now("px_unexpected");
            else check_output("dp_px", dp_px, exp_px.pop_front());
            check_output("inflight_bound", ((mon_px / TB_BUFF) - mon_fwd) < TB_MAX, 1);
            mon_px++;
        end
        if (dp_median_rd || out_median_wr) begin
            check_output("med_handshake", {dp_median_rd, out_median_wr, dp_median_empty, out_median_full}, 4'b1100);
            if (exp_med.size() == 0) fail_now("median_unexpected");
            else check_output("out_median", out_median, exp_med.pop_front());
            check_output("windows_done_run", windows_done, exp_done);
            exp_done++;
            mon_fwd++;
        end
    end

    initial begin
        int c;
        bit h0, h1;
        n_checks = 0;
        n_fail = 0;
        #2;
        do_reset();

        $display("[TB] two full windows with no results returned");
        enable = 1'b1;
        apply_stimulus(36, 0);
        wait_px(32, 200, "t1_px_count");
        repeat (8) @(negedge clock);
        check_output("t1_no_overrun", px_wr_total, 32);
        #4;
        check_output("t1_rd_blocked", {in_px_rd, busy}, 2'b01);
        @(negedge clock);

        $display("[TB] return medians 42 and 77");
        res_q.push_back(8'd42); exp_med.push_back(8'd42);
        res_q.push_back(8'd77); exp_med.push_back(8'd77);
        wait_med(2, 50, "t2_medians");
        check_output("t2_windows_done", windows_done, 2);
        c = (med_cyc_q.size() != 0) ? med_cyc_q[0] : -10;
        h1 = px_hist.exists(c + 1);
        check_output("t2_resume", h1, 1);

        $display("[TB] downstream full toggling");
        do_reset();
        enable = 1'b1; chain_auto = 1; track_med = 1; full_mode = 1;
        apply_stimulus(16, 1);
        wait_px(16, 100, "t3_px_count");
        wait_med(1, 50, "t3_median");
        full_mode = 0;
        check_output("t3_windows_done", windows_done, 1);

        $display("[TB] enable dropped mid-window");
        do_reset();
        enable = 1'b1;
        apply_stimulus(20, 0);
        wait_px(5, 50, "t4_px5");
        enable = 1'b0;
        wait_px(16, 50, "t4_px16");
        repeat (6) @(negedge clock);
        check_output("t4_no_new_window", px_wr_total, 16);
        check_output("t4_busy_held", busy, 1);
        res_q.push_back(8'd99); exp_med.push_back(8'd99);
        wait_med(1, 50, "t4_median");
        check_output("t4_busy_clear", busy, 0);
        check_output("t4_windows_done", windows_done, 1);

        $display("[TB] window close and result read in one cycle");
        do_reset();
        enable = 1'b1;
        apply_stimulus(31, 0);
        wait_px(31, 100, "t5_px31");
        res_q.push_back(8'd55); exp_med.push_back(8'd55);
        apply_stimulus(17, 0);
        wait_px(48, 100, "t5_px48");
        c = (med_cyc_q.size() != 0) ? med_cyc_q[0] : -10;
        h0 = px_hist.exists(c);
        h1 = px_hist.exists(c + 1);
        check_output("t5_overlap", {h0, h1}, 2'b11);
        apply_stimulus(1, 0);
        repeat (5) @(negedge clock);
        check_output("t5_stall_after_w3", px_wr_total, 48);
        check_output("t5_windows_done", windows_done, 1);

        $display("[TB] result with nothing in flight");
        do_reset();
        res_q.push_back(8'hAA);
        repeat (3) @(negedge clock);
        #4;
        check_output("t6_err_set", {dp_median_rd, err_unexpected}, 2'b01);
        @(negedge clock);
        res_q.delete();
        repeat (3) @(negedge clock);
        check_output("t6_err_sticky", err_unexpected, 1);

        $display("[TB] async reset mid-window");
        do_reset();
        enable = 1'b1;
        apply_stimulus(16, 0);
        wait_px(6, 50, "rst_px6");
        #2;
        do_reset();
        enable = 1'b1; chain_auto = 1; track_med = 1;
        apply_stimulus(16, 1);
        wait_px(14, 50, "rst_px14");
        enable = 1'b0;
        wait_med(1, 50, "rst_median");
        repeat (2) @(negedge clock);
        check_output("rst_px_cnt_cleared", busy, 0);

        $display("[TB] randomized traffic");
        do_reset();
        chain_auto = 1; track_med = 1; full_mode = 2; src_gap = 1; res_gap = 1; cons_gap = 1;
        enable = 1'b1;
        for (int w = 0; w < 12; w++) begin
            apply_stimulus(16, 1);
            if ($urandom_range(0, 2) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 20)) @(negedge clock);
                enable = 1'b1;
            end
        end
        wait_med(12, 5000, "rand_medians");
        check_output("rand_windows_done", windows_done, 12);
        check_output("rand_px_total", px_wr_total, 192);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
